button_input: RTL and testbench

BUTTON_INPUT -- requirements
Module: button_input

---
 rtl/button_input.sv | 121 ++++++++++++
 tb/tb_button_input.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_input.sv
// Pushbutton front end: synchronizer, debouncer, press/release/long-press
// strobes and a wrapping press counter.
module button_input #(
    parameter logic [15:0] DEBOUNCE_CYCLES   = 16'd50000,
    parameter logic [31:0] LONG_PRESS_CYCLES = 32'd25000000
) (
    input  logic       input_clk,
    input  logic       reset,
    input  logic       btn_n,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    logic        sync1;
    logic        sync2;
    logic        s;
    logic [15:0] db_cnt;
    logic        db_hit;
    logic        press_acc;
    logic        rel_acc;
    logic [31:0] hold_cnt;
    logic        long_fire;
    state_t      state;
    state_t      state_next;

    // Synchronizer idles at 1 so a held button is never seen during reset.
    always_ff @(posedge input_clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    assign s         = ~sync2;
    assign db_hit    = (s != btn_level) &&
                       (db_cnt == DEBOUNCE_CYCLES - 16'd1);
    assign press_acc = db_hit & ~btn_level;
    assign rel_acc   = db_hit & btn_level;

    always_ff @(posedge input_clk) begin
        if (reset) begin
            db_cnt        <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
        end else begin
            press_pulse   <= press_acc;
            release_pulse <= rel_acc;
            if (s == btn_level || db_hit) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
            if (db_hit) begin
                btn_level <= ~btn_level;
            end
            if (press_acc) begin
                press_count <= press_count + 8'd1;
            end
        end
    end

    // A release on the long-fire cycle takes priority over the long strobe.
    always_comb begin
        state_next = state;
        long_fire  = 1'b0;
        unique case (state)
            IDLE: begin
                if (press_acc) begin
                    state_next = PRESSED;
                end
            end
            PRESSED: begin
                if (rel_acc) begin
                    state_next = IDLE;
                end else if (hold_cnt == LONG_PRESS_CYCLES - 32'd1) begin
                    long_fire  = 1'b1;
                    state_next = LONG;
                end
            end
            LONG: begin
                if (rel_acc) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge input_clk) begin
        if (reset) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            long_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            long_pulse <= long_fire;
            if (press_acc) begin
                hold_cnt <= '0;
            end else if (state == PRESSED) begin
                hold_cnt <= hold_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_button_input.sv
// Scoreboard bench for button_input: window-based reference model pushes
// expected strobes, a negedge monitor pops and compares them.
module tb_button_input;

    localparam int DI = 4;
    localparam int LI = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_n = 1'b1;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    always #5 clk = ~clk;

    button_input #(
        .DEBOUNCE_CYCLES(16'd4),
        .LONG_PRESS_CYCLES(32'd10)
    ) dut (
        .input_clk(clk),
        .reset(reset),
        .btn_n(btn_n),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .press_count(press_count)
    );

    typedef struct {
        int   k;
        bit   p;
        bit   r;
        bit   l;
    } ev_t;

    ev_t sbq[$];
    int  compared = 0;
    int  mismatched = 0;
    int  edge_n = -1;
    bit  samp_b[$];
    bit  samp_r[$];
    int  last_rst = 0;
    bit  m_level = 1'b0;
    int  press_edge = 0;
    bit  long_done = 1'b1;
    int  m_count = 0;
    int  n_press = 0;
    int  n_rel = 0;
    int  n_long = 0;

    // Pressed-ness seen by the debouncer at edge m: raw pin sampled two
    // edges earlier, forced to "released" just after a reset edge.
    function automatic bit s_at(int m);
        if (m < 2) return 1'b0;
        if (samp_r[m-1] || samp_r[m-2]) return 1'b0;
        return !samp_b[m-2];
    endfunction

    initial begin : model
        int  k;
        bit  tog, old, rel, prs, lng;
        ev_t e;
        forever begin
            @(posedge clk);
            edge_n = edge_n + 1;
            k = edge_n;
            samp_b.push_back(btn_n);
            samp_r.push_back(reset);
            if (reset) begin
                m_level   = 1'b0;
                last_rst  = k;
                m_count   = 0;
                long_done = 1'b1;
            end else begin
                old = m_level;
                tog = (k - DI + 1 > last_rst);
                for (int m = k - DI + 1; m <= k; m++) begin
                    if (m >= 0 && s_at(m) == old) tog = 1'b0;
                end
                rel = tog && old;
                prs = tog && !old;
                lng = old && !long_done && (k - press_edge == LI) && !rel;
                if (tog) m_level = !old;
                if (prs) begin
                    press_edge = k;
                    long_done  = 1'b0;
                    m_count    = (m_count + 1) % 256;
                end
                if (lng || rel) long_done = 1'b1;
                if (prs || rel || lng) begin
                    e.k = k;
                    e.p = prs;
                    e.r = rel;
                    e.l = lng;
                    sbq.push_back(e);
                end
            end
        end
    end

    initial begin : monitor
        ev_t e;
        bit  have;
        logic [7:0] want_cnt;
        forever begin
            @(negedge clk);
            if (edge_n >= 0) begin
                want_cnt = m_count[7:0];
                compared = compared + 1;
                if (btn_level !== m_level || press_count !== want_cnt) begin
                    mismatched = mismatched + 1;
                    $display("FAIL level/count edge %0d: got level=%b count=%0d, want level=%b count=%0d",
                             edge_n, btn_level, press_count, m_level, want_cnt);
                end
                have = (sbq.size() > 0) && (sbq[0].k == edge_n);
                if (have) begin
                    e = sbq.pop_front();
                end else begin
                    e.k = edge_n;
                    e.p = 1'b0;
                    e.r = 1'b0;
                    e.l = 1'b0;
                end
                if (have || press_pulse || release_pulse || long_pulse) begin
                    compared = compared + 1;
                    if ({press_pulse, release_pulse, long_pulse} !== {e.p, e.r, e.l}) begin
                        mismatched = mismatched + 1;
                        $display("FAIL strobes edge %0d: got p/r/l=%b%b%b, want %b%b%b",
                                 edge_n, press_pulse, release_pulse, long_pulse, e.p, e.r, e.l);
                    end
                end
                n_press = n_press + int'(press_pulse === 1'b1);
                n_rel   = n_rel + int'(release_pulse === 1'b1);
                n_long  = n_long + int'(long_pulse === 1'b1);
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        compared = compared + 1;
        if (got !== want) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick(bit b, bit r);
        @(posedge clk);
        #1;
        btn_n = b;
        reset = r;
    endtask

    task automatic hold(bit b, int n);
        repeat (n) tick(b, 1'b0);
    endtask

    initial begin : stim
        int base_p, base_r, base_l, len;
        bit b;

        for (int i = 0; i < 4; i++) tick(1'($urandom_range(0, 1)), 1'b1);
        @(negedge clk);
        chk("reset outputs", {btn_level, press_pulse, release_pulse,
                              long_pulse, press_count}, 0);
        tick(1'b1, 1'b0);
        hold(1'b1, 8);

        // clean press, long fire, release
        tick(1'b0, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            tick(1'b0, 1'b0);
            @(negedge clk);
            chk("press latency", press_pulse, 32'(i == 6));
            chk("long timing", long_pulse, 32'(i == 16));
            if (i >= 6) chk("level held", btn_level, 1);
            if (i == 6) chk("first count", press_count, 1);
        end
        tick(1'b1, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b0);
            @(negedge clk);
            chk("release latency", release_pulse, 32'(i == 6));
            chk("no relong", long_pulse, 0);
        end

        // release lands on the long-fire edge
        tick(1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick(i >= 10, 1'b0);
            @(negedge clk);
            chk("race long", long_pulse, 0);
            if (i == 16) begin
                chk("race release", release_pulse, 1);
                chk("race level", btn_level, 0);
            end
        end
        hold(1'b1, 10);

        // bounce 3,1,2 low with 1-cycle highs, then steady
        base_p = n_press;
        hold(1'b0, 3); hold(1'b1, 1);
        hold(1'b0, 1); hold(1'b1, 1);
        hold(1'b0, 2); hold(1'b1, 1);
        hold(1'b0, 12);
        hold(1'b1, 12);
        chk("bounce presses", n_press - base_p, 1);

        // reset mid-press
        hold(1'b0, 8);
        base_r = n_rel;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        @(negedge clk);
        chk("mid reset outputs", {btn_level, press_pulse, release_pulse,
                                  long_pulse, press_count}, 0);
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 1'b0);
            @(negedge clk);
            chk("post reset press", press_pulse, 32'(i == 6));
        end
        chk("no release on reset", n_rel - base_r, 0);
        hold(1'b1, 12);

        // 257 presses wrap the counter
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        hold(1'b1, 6);
        base_p = n_press;
        base_r = n_rel;
        base_l = n_long;
        for (int i = 0; i < 257; i++) begin
            hold(1'b0, 7);
            hold(1'b1, 7);
        end
        @(negedge clk);
        chk("wrap count", press_count, 1);
        chk("wrap presses", n_press - base_p, 257);
        chk("wrap releases", n_rel - base_r, 257);
        chk("wrap longs", n_long - base_l, 0);

        // random bounce / hold traffic
        for (int i = 0; i < 400; i++) begin
            b = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 5))
                                             : int'($urandom_range(5, 20));
            if ($urandom_range(0, 49) == 0) tick(b, 1'b1);
            hold(b, len);
        end
        hold(1'b1, 12);
        @(negedge clk);
        chk("scoreboard drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
